// File: rtl/vpu_pkg.sv
// ----------------------------------------------------------------------------
// vpu_pkg -- shared vector-unit definitions.
//   SEW_*          : element-width encodings seen on i_element_width
//   vseq_state_e   : element sequencer FSM states
//   sew_norm()     : folds unsupported SEW codes onto e32
// Optional feature macro used by importers: VPU_FIRST_FAULT_EN
// ----------------------------------------------------------------------------
package vpu_pkg;

    localparam logic [2:0] SEW_8  = 3'b000;
    localparam logic [2:0] SEW_16 = 3'b101;
    localparam logic [2:0] SEW_32 = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } vseq_state_e;

    // Anything that is not e8/e16 is treated as e32.
    function automatic logic [2:0] sew_norm(input logic [2:0] sew);
        case (sew)
            SEW_8:   sew_norm = SEW_8;
            SEW_16:  sew_norm = SEW_16;
            default: sew_norm = SEW_32;
        endcase
    endfunction

endpackage

// File: rtl/vector_element_sequencer.sv
// ----------------------------------------------------------------------------
// vector_element_sequencer -- walks element indices vstart..vl-1 of a vector
// operation, one per non-stalled cycle, and reports the effective vl.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_start                 start an operation (only looked at in IDLE)
//   i_vl, i_vstart          element count / first element index
//   i_element_width         SEW code (000 e8, 101 e16, 110/other e32)
//   i_first_fault,
//   i_mask_skip             operation attributes
//   i_stall                 downstream not ready, hold current element
//   i_fault_occur           fault on the current element
//   o_address               current element index
//   o_element_width,
//   o_first_fault,
//   o_mask_skip             latched attributes
//   o_valid, o_busy, o_done element valid / op active / completion pulse
//   o_new_vl, o_vl_trunc,
//   o_trap                  first-fault results, held until next start
//
// Macro VPU_FIRST_FAULT_EN enables first-fault truncation/trap handling;
// without it i_fault_occur is ignored and o_new_vl is always the latched vl.
// ----------------------------------------------------------------------------
module vector_element_sequencer
    import vpu_pkg::*;
#(
    parameter int VLEN = 256
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic [$clog2(VLEN):0]    i_vl,
    input  logic [$clog2(VLEN)-1:0]  i_vstart,
    input  logic [2:0]               i_element_width,
    input  logic                     i_first_fault,
    input  logic                     i_mask_skip,
    input  logic                     i_stall,
    input  logic                     i_fault_occur,
    output logic [$clog2(VLEN)-1:0]  o_address,
    output logic [2:0]               o_element_width,
    output logic                     o_first_fault,
    output logic                     o_mask_skip,
    output logic                     o_valid,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [$clog2(VLEN):0]    o_new_vl,
    output logic                     o_vl_trunc,
    output logic                     o_trap
);

    localparam int AW = $clog2(VLEN);
    localparam int VW = AW + 1;

    vseq_state_e     r_state, w_next;
    logic [VW-1:0]   r_vl;
    logic [AW-1:0]   r_cnt;
    logic [2:0]      r_ew;
    logic            r_ff, r_ms;
    logic            w_accept, w_last, w_fault_hit, w_can_run;

    assign w_accept  = (r_state == ST_IDLE) && i_start;
    assign w_can_run = ({1'b0, i_vstart} < i_vl);
    assign w_last    = ({1'b0, r_cnt} == (r_vl - VW'(1)));

`ifdef VPU_FIRST_FAULT_EN
    // Only meaningful while an element is presented (RUN).
    assign w_fault_hit = (r_state == ST_RUN) && r_ff && i_fault_occur;
`else
    logic w_unused_fault;
    assign w_unused_fault = i_fault_occur;
    assign w_fault_hit    = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        o_valid = 1'b0;
        o_busy  = 1'b0;
        o_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) w_next = w_can_run ? ST_RUN : ST_DONE;
            end
            ST_RUN: begin
                o_valid = 1'b1;
                o_busy  = 1'b1;
                // A fault terminates even while stalled.
                if (w_fault_hit || (!i_stall && w_last)) w_next = ST_DONE;
            end
            ST_DONE: begin
                o_busy = 1'b1;
                o_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Operation latches and element counter. The counter stops at vl-1,
    // so the address never wraps.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vl  <= '0;
            r_cnt <= '0;
            r_ew  <= '0;
            r_ff  <= 1'b0;
            r_ms  <= 1'b0;
        end else if (w_accept) begin
            r_vl  <= i_vl;
            r_cnt <= i_vstart;
            r_ew  <= sew_norm(i_element_width);
            r_ff  <= i_first_fault;
            r_ms  <= i_mask_skip;
        end else if (r_state == ST_RUN && !w_fault_hit && !i_stall && !w_last) begin
            r_cnt <= r_cnt + AW'(1);
        end
    end

`ifdef VPU_FIRST_FAULT_EN
    logic [VW-1:0] r_new_vl;
    logic          r_trunc, r_trap;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_new_vl <= '0;
            r_trunc  <= 1'b0;
            r_trap   <= 1'b0;
        end else if (w_accept) begin
            r_new_vl <= i_vl;
            r_trunc  <= 1'b0;
            r_trap   <= 1'b0;
        end else if (w_fault_hit) begin
            // Faulting on the first element cannot be truncated away.
            if (r_cnt != '0) begin
                r_new_vl <= {1'b0, r_cnt};
                r_trunc  <= 1'b1;
            end else begin
                r_trap   <= 1'b1;
            end
        end
    end

    assign o_new_vl   = r_new_vl;
    assign o_vl_trunc = r_trunc;
    assign o_trap     = r_trap;
`else
    assign o_new_vl   = r_vl;
    assign o_vl_trunc = 1'b0;
    assign o_trap     = 1'b0;
`endif

    assign o_address       = r_cnt;
    assign o_element_width = r_ew;
    assign o_first_fault   = r_ff;
    assign o_mask_skip     = r_ms;

endmodule

// File: tb/tb_vector_element_sequencer.sv
// ----------------------------------------------------------------------------
// tb_vector_element_sequencer -- directed and randomized operations against a
// behavioural element-walk model. Expected first-fault behaviour follows
// VPU_FIRST_FAULT_EN as compiled.
// ----------------------------------------------------------------------------
module tb_vector_element_sequencer;

    localparam int VLEN = 256;
    localparam int AW   = $clog2(VLEN);
`ifdef VPU_FIRST_FAULT_EN
    localparam bit FF_EN = 1'b1;
`else
    localparam bit FF_EN = 1'b0;
`endif

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_start = 1'b0;
    logic [AW:0]   i_vl = '0;
    logic [AW-1:0] i_vstart = '0;
    logic [2:0]    i_element_width = '0;
    logic          i_first_fault = 1'b0, i_mask_skip = 1'b0;
    logic          i_stall = 1'b0, i_fault_occur = 1'b0;
    logic [AW-1:0] o_address;
    logic [2:0]    o_element_width;
    logic          o_first_fault, o_mask_skip, o_valid, o_busy, o_done;
    logic [AW:0]   o_new_vl;
    logic          o_vl_trunc, o_trap;

    int total = 0;
    int bad   = 0;

    vector_element_sequencer #(.VLEN(VLEN)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_vl(i_vl),
        .i_vstart(i_vstart), .i_element_width(i_element_width),
        .i_first_fault(i_first_fault), .i_mask_skip(i_mask_skip),
        .i_stall(i_stall), .i_fault_occur(i_fault_occur),
        .o_address(o_address), .o_element_width(o_element_width),
        .o_first_fault(o_first_fault), .o_mask_skip(o_mask_skip),
        .o_valid(o_valid), .o_busy(o_busy), .o_done(o_done),
        .o_new_vl(o_new_vl), .o_vl_trunc(o_vl_trunc), .o_trap(o_trap)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sew_model(input int e);
        if (e == 0) return 0;
        if (e == 5) return 5;
        return 6;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, ".addr"},  32'(o_address), 0);
        chk({tag, ".ew"},    32'(o_element_width), 0);
        chk({tag, ".ff"},    32'(o_first_fault), 0);
        chk({tag, ".ms"},    32'(o_mask_skip), 0);
        chk({tag, ".valid"}, 32'(o_valid), 0);
        chk({tag, ".busy"},  32'(o_busy), 0);
        chk({tag, ".done"},  32'(o_done), 0);
        chk({tag, ".nvl"},   32'(o_new_vl), 0);
        chk({tag, ".trunc"}, 32'(o_vl_trunc), 0);
        chk({tag, ".trap"},  32'(o_trap), 0);
    endtask

    // One operation. The model walks idx from vstart to vl-1, staying on an
    // element for every stalled cycle; a first fault ends the walk early.
    // rst_at >= 0 pulses reset while that element is presented.
    task automatic run_op(input string tag, input int vl, input int vstart,
                          input int ew, input int ff, input int ms,
                          input int stall_pct, input int fault_at,
                          input int stall_addr, input int stall_n,
                          input int rst_at, output int ncyc);
        int  idx, stalls_left, exp_nvl, exp_tr, exp_tp;
        bit  stall, fault, fin;
        ncyc = 0;
        exp_nvl = vl; exp_tr = 0; exp_tp = 0;
        @(negedge i_clk);
        i_start = 1'b1; i_vl = (AW+1)'(vl); i_vstart = AW'(vstart);
        i_element_width = 3'(ew); i_first_fault = ff[0]; i_mask_skip = ms[0];
        i_stall = 1'b0; i_fault_occur = 1'b0;
        @(negedge i_clk);
        i_start = 1'b0;
        if (vstart < vl) begin
            idx = vstart; stalls_left = stall_n; fin = 0;
            while (!fin) begin
                chk({tag, ".valid"}, 32'(o_valid), 1);
                chk({tag, ".busy"},  32'(o_busy), 1);
                chk({tag, ".done"},  32'(o_done), 0);
                chk({tag, ".addr"},  32'(o_address), idx);
                chk({tag, ".ew"},    32'(o_element_width), sew_model(ew));
                chk({tag, ".ff"},    32'(o_first_fault), ff);
                chk({tag, ".ms"},    32'(o_mask_skip), ms);
                if (idx == rst_at) begin
                    i_rst = 1'b1;
                    @(negedge i_clk);
                    i_rst = 1'b0; i_stall = 1'b0; i_fault_occur = 1'b0; i_start = 1'b0;
                    chk_all_zero({tag, ".rst"});
                    return;
                end
                if (idx == stall_addr && stalls_left > 0) begin
                    stall = 1; stalls_left--;
                end else begin
                    stall = (($urandom % 100) < stall_pct);
                end
                fault = (idx == fault_at) ? 1'b1 : (ff != 0 ? 1'b0 : 1'($urandom % 2));
                i_stall = stall; i_fault_occur = fault;
                // Start requests during RUN must be ignored.
                i_start = 1'($urandom % 4 == 0);
                i_vl = (AW+1)'($urandom); i_vstart = AW'($urandom);
                i_element_width = 3'($urandom); i_first_fault = 1'($urandom);
                i_mask_skip = 1'($urandom);
                if (FF_EN && ff != 0 && fault) begin
                    fin = 1;
                    if (idx > 0) begin exp_nvl = idx; exp_tr = 1; end
                    else exp_tp = 1;
                end else if (!stall) begin
                    if (idx == vl - 1) fin = 1;
                    else idx++;
                end
                @(negedge i_clk);
                ncyc++;
                if (ncyc > 2000) begin
                    chk({tag, ".timeout"}, 1, 0);
                    fin = 1;
                end
            end
            i_start = 1'b0; i_stall = 1'b0; i_fault_occur = 1'b0;
        end
        chk({tag, ".d_done"},  32'(o_done), 1);
        chk({tag, ".d_valid"}, 32'(o_valid), 0);
        chk({tag, ".d_busy"},  32'(o_busy), 1);
        chk({tag, ".d_nvl"},   32'(o_new_vl), exp_nvl);
        chk({tag, ".d_trunc"}, 32'(o_vl_trunc), exp_tr);
        chk({tag, ".d_trap"},  32'(o_trap), exp_tp);
        @(negedge i_clk);
        chk({tag, ".i_done"},  32'(o_done), 0);
        chk({tag, ".i_busy"},  32'(o_busy), 0);
        chk({tag, ".i_valid"}, 32'(o_valid), 0);
        chk({tag, ".i_nvl"},   32'(o_new_vl), exp_nvl);
        chk({tag, ".i_trunc"}, 32'(o_vl_trunc), exp_tr);
        chk({tag, ".i_trap"},  32'(o_trap), exp_tp);
    endtask

    initial begin
        int n, vl, vs;
        i_rst = 1'b1;
        i_start = 1'b1;   // must not matter under reset
        @(negedge i_clk);
        @(negedge i_clk);
        chk_all_zero("reset");
        i_rst = 1'b0; i_start = 1'b0;
        @(negedge i_clk);
        chk_all_zero("idle");

        // Basic walk vl=4 from 0, no stall.
        run_op("basic", 4, 0, 0, 0, 0, 0, -1, -1, 0, -1, n);
        chk("basic.len", n, 4);
        // Two stall cycles on address 1: six RUN cycles.
        run_op("stall", 4, 0, 5, 0, 1, 0, -1, 1, 2, -1, n);
        chk("stall.len", n, 6);
        // vstart == vl: straight to DONE.
        run_op("empty", 5, 5, 6, 0, 0, 0, -1, -1, 0, -1, n);
        run_op("vl0", 0, 0, 3, 1, 0, 0, -1, -1, 0, -1, n);
        // First-fault truncation and trap.
        run_op("ff_mid", 8, 0, 6, 1, 0, 0, 3, -1, 0, -1, n);
        run_op("ff_zero", 8, 0, 0, 1, 1, 0, 0, -1, 0, -1, n);
        // Fault while stalled on the faulting element.
        run_op("ff_stall", 8, 2, 5, 1, 0, 0, 4, 4, 3, -1, n);
        // Noise on i_fault_occur without first-fault.
        run_op("noff", 8, 0, 7, 0, 1, 30, 3, -1, 0, -1, n);
        // Reset mid-run, then clean restart.
        run_op("rst", 8, 0, 5, 1, 1, 0, -1, -1, 0, 2, n);
        run_op("after_rst", 8, 0, 0, 0, 0, 0, -1, -1, 0, -1, n);
        chk("after_rst.len", n, 8);
        // Top of the index range, no wrap.
        run_op("top", VLEN, VLEN - 3, 5, 0, 0, 20, -1, -1, 0, -1, n);

        for (int k = 0; k < 40; k++) begin
            vl = $urandom_range(0, 24);
            vs = $urandom_range(0, 26);
            run_op("rand", vl, vs, $urandom_range(0, 7), $urandom_range(0, 1),
                   $urandom_range(0, 1), 25,
                   ($urandom % 3 == 0) ? $urandom_range(0, 24) : -1,
                   -1, 0, -1, n);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
